// File: rtl/fsm_pattern_tx_if.sv
// fsm_pattern_tx_if
//   Handshake/data bundle between a pattern-transmitter controller and the
//   fsm_pattern_tx serial bit-pattern transmitter.
//
//   Signals:
//     start    - begin a transfer (sampled by the transmitter only when idle)
//     pattern  - parallel bits to send; bit len-1 goes out first
//     len      - pattern bits per pass (clamped to WIDTH by the transmitter)
//     repeats  - extra passes; total passes = repeats + 1
//     abort    - cancel the transfer in progress
//     ser_out  - serial data bit (0 whenever ser_valid is 0)
//     ser_valid- ser_out carries a pattern bit
//     busy     - transmitter is not idle
//     done     - one-cycle pulse at normal completion
//
//   Modports:
//     master - controller side (drives start/pattern/len/repeats/abort)
//     slave  - transmitter side (drives ser_out/ser_valid/busy/done)
interface fsm_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int REP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] repeats;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, repeats, abort,
    input  ser_out, ser_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, repeats, abort,
    output ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/fsm_pattern_tx.sv
// fsm_pattern_tx
//   Serial bit-pattern transmitter. On a start strobe in IDLE it latches a
//   parallel pattern, an effective length L = min(len, WIDTH) and a repeat
//   count, then shifts the pattern out MSB-first (bit L-1 down to bit 0),
//   one bit per clock, for repeats+1 back-to-back passes. A one-cycle done
//   pulse marks normal completion; abort cancels silently. A start with
//   len = 0 produces only the done pulse.
//
//   Ports:
//     clk   - single clock, rising edge
//     reset - synchronous, active-high; priority over every other input
//     bus   - fsm_pattern_tx_if.slave (start/pattern/len/repeats/abort in,
//             ser_out/ser_valid/busy/done out, all outputs registered)
module fsm_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int REP_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  fsm_pattern_tx_if.slave bus
);

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Clamp a requested length to the physical pattern width.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    if (l > WIDTH_L) return WIDTH_L;
    return l;
  endfunction

  // Select bit 'pos' of a pattern. Done with a mask so the index width
  // need not match the pattern width.
  function automatic logic bit_at(input logic [WIDTH-1:0] p,
                                  input logic [LEN_W-1:0] pos);
    return |(p & (ONE_W << pos));
  endfunction

  state_t           state;
  logic [LEN_W-1:0] bit_idx;   // position within the pass, 0 = first bit sent
  logic [REP_W-1:0] pass_cnt;  // passes completed so far, 0..repeats
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             busy_q;
  logic             done_q;

  // Latched transfer parameters (data only, never reset).
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] rep_q;

  logic [LEN_W-1:0] len_eff;
  logic             accept;
  logic             first_bit;
  logic             restart_bit;
  logic [LEN_W-1:0] next_idx;
  logic             next_bit;
  logic             last_bit;
  logic             last_pass;

  assign len_eff     = sat_len(bus.len);
  assign accept      = (state == IDLE) && bus.start && (len_eff != '0);
  // First bit comes straight from the input pattern so it can be
  // registered on the same edge that accepts the start.
  assign first_bit   = bit_at(bus.pattern, len_eff - LEN_ONE);
  assign restart_bit = bit_at(pat_q, len_q - LEN_ONE);
  assign next_idx    = bit_idx + LEN_ONE;
  assign next_bit    = bit_at(pat_q, len_q - LEN_ONE - next_idx);
  assign last_bit    = (bit_idx == len_q - LEN_ONE);
  assign last_pass   = (pass_cnt == rep_q);

  always_ff @(posedge clk) begin
    if (accept) begin
      pat_q <= bus.pattern;
      len_q <= len_eff;
      rep_q <= bus.repeats;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      pass_cnt    <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          bit_idx     <= '0;
          pass_cnt    <= '0;
          if (bus.start) begin
            if (len_eff != '0) begin
              ser_out_q   <= first_bit;
              ser_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state       <= SHIFT;
            end else begin
              // Empty transfer: report completion without sending bits.
              busy_q <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end

        SHIFT: begin
          if (bus.abort) begin
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            bit_idx     <= '0;
            pass_cnt    <= '0;
            state       <= IDLE;
          end else if (last_bit) begin
            if (!last_pass) begin
              // Next pass starts on the very next cycle, no gap.
              pass_cnt  <= pass_cnt + REP_ONE;
              bit_idx   <= '0;
              ser_out_q <= restart_bit;
            end else begin
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              done_q      <= 1'b1;
              bit_idx     <= '0;
              pass_cnt    <= '0;
              state       <= DONE;
            end
          end else begin
            bit_idx   <= next_idx;
            ser_out_q <= next_bit;
          end
        end

        DONE: begin
          // start and abort are both ignored here.
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          bit_idx     <= '0;
          pass_cnt    <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// tb_fsm_pattern_tx
//   Bench for fsm_pattern_tx. Each driven cycle pushes the required output
//   vector {ser_out, ser_valid, busy, done} for the following cycle into a
//   scoreboard queue; a negedge monitor pops and compares.
module tb_fsm_pattern_tx;
  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int REP_W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fsm_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

  fsm_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] v;     // {ser_out, ser_valid, busy, done}
    string      tag;
  } exp_t;

  typedef struct {
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [3:0]  repeats;
    logic [31:0] bits;   // required serial stream, first bit at bits[n-1]
    int          n;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic so, input logic sv, input logic bz,
                              input logic dn, input string tag);
    exp_t e;
    e.v   = {so, sv, bz, dn};
    e.tag = tag;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [3:0] got;
      e   = sb.pop_front();
      got = {bus.ser_out, bus.ser_valid, bus.busy, bus.done};
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got {out,vld,busy,done}=%b want %b", e.tag, got, e.v);
      end
    end
  end

  // Inputs are set before calling; the DUT samples them on this edge and
  // e describes the cycle that follows.
  task automatic step(input exp_t e);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic xfer(input vec_t t, input string tag);
    logic b;
    bus.pattern = t.pattern;
    bus.len     = t.len;
    bus.repeats = t.repeats;
    bus.start   = 1'b1;
    if (t.n == 0) begin
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, {tag, " empty done"}));
      bus.start = 1'b0;
    end else begin
      for (int i = 0; i < t.n; i++) begin
        b = t.bits[5'(t.n - 1 - i)];
        step(mk(b, 1'b1, 1'b1, 1'b0, $sformatf("%s bit%0d", tag, i)));
        bus.start = 1'b0;
        // Latched values must be used, whatever the inputs do now.
        bus.pattern = ~t.pattern;
        bus.len     = 4'($urandom_range(0, 15));
        bus.repeats = 4'($urandom_range(0, 15));
      end
      step(mk(1'b0, 1'b0, 1'b1, 1'b1, {tag, " done"}));
    end
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, {tag, " idle"}));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1);
  end

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h07, 4'd4,  4'd0,  32'h0000_0007, 4};   // 0111
    vecs[1] = '{8'h02, 4'd2,  4'd2,  32'h0000_002A, 6};   // 10 x3
    vecs[2] = '{8'hA5, 4'd8,  4'd0,  32'h0000_00A5, 8};
    vecs[3] = '{8'hB3, 4'd15, 4'd0,  32'h0000_00B3, 8};   // clamped to 8
    vecs[4] = '{8'h05, 4'd3,  4'd1,  32'h0000_002D, 6};   // 101 x2
    vecs[5] = '{8'h01, 4'd1,  4'd3,  32'h0000_000F, 4};   // single bit x4
    vecs[6] = '{8'hF3, 4'd5,  4'd0,  32'h0000_0013, 5};   // upper bits unused
    vecs[7] = '{8'hFF, 4'd0,  4'd0,  32'h0000_0000, 0};   // empty transfer
    vecs[8] = '{8'h02, 4'd2,  4'd15, 32'hAAAA_AAAA, 32};  // 16 passes

    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.repeats = '0;
    bus.abort   = 1'b0;
    reset       = 1'b1;

    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "reset0"));
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "reset1"));
    reset = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "idle0"));
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "idle1"));

    for (int i = 0; i < 9; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // start during the second bit and during DONE; pattern changes mid-way.
    bus.pattern = 8'h07; bus.len = 4'd4; bus.repeats = 4'd0; bus.start = 1'b1;
    step(mk(1'b0, 1'b1, 1'b1, 1'b0, "ign b0"));
    bus.start = 1'b0;
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, "ign b1"));
    bus.start = 1'b1; bus.pattern = 8'h00; bus.len = 4'd2;
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, "ign b2"));
    bus.start = 1'b0;
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, "ign b3"));
    step(mk(1'b0, 1'b0, 1'b1, 1'b1, "ign done"));
    bus.start = 1'b1;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "ign start in done"));
    bus.start = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "ign idle"));

    // abort is ignored in IDLE, honoured at the third bit of SHIFT.
    bus.pattern = 8'hC9; bus.len = 4'd8; bus.repeats = 4'd1;
    bus.start = 1'b1; bus.abort = 1'b1;
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, "abt b0"));
    bus.start = 1'b0; bus.abort = 1'b0;
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, "abt b1"));
    step(mk(1'b0, 1'b1, 1'b1, 1'b0, "abt b2"));
    bus.abort = 1'b1;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "abt cut"));
    bus.abort = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "abt no done0"));
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "abt no done1"));
    xfer(vecs[4], "after abort");

    // reset mid-transfer beats a simultaneous start; restart right after.
    bus.pattern = 8'hA5; bus.len = 4'd8; bus.repeats = 4'd0; bus.start = 1'b1;
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, "rst b0"));
    bus.start = 1'b0;
    step(mk(1'b0, 1'b1, 1'b1, 1'b0, "rst b1"));
    reset = 1'b1; bus.start = 1'b1;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, "rst mid"));
    reset = 1'b0;
    xfer(vecs[0], "after reset");

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
